// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, station tags, "no value" sentinels,
// reservation-station state encoding and payload structs.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned REG_W  = 4;

    // Functional-unit opcodes
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;

    // Producer tags
    localparam logic [TAG_W-1:0] FREE_REGISTER    = 3'd0;
    localparam logic [TAG_W-1:0] RES_STATION_ADD1 = 3'd1;
    localparam logic [TAG_W-1:0] RES_STATION_ADD2 = 3'd2;

    // Sentinels for "no value" / "value ready"
    localparam logic [DATA_W-1:0] VJ_VK_SEM_VALOR = 16'hFFF0;
    localparam logic [TAG_W-1:0]  QJ_QK_SEM_VALOR = 3'b000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPS  = 2'd1,
        EXEC      = 2'd2,
        WRITEBACK = 2'd3
    } rs_state_e;

    // Captured instruction held by the station
    typedef struct packed {
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [OP_W-1:0]   ufop;
        logic [REG_W-1:0]  r_target;
    } rs_entry_t;

    // Broadcast payload driven onto the common data bus
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  target;
    } cdb_payload_t;

endpackage

// File: rtl/reservation_station_add_if.sv
// Dispatch, CDB snoop and CDB broadcast signals of the add reservation station.
interface reservation_station_add_if;
    import tomasulo_pkg::*;

    logic              Enable_VQ;
    logic [DATA_W-1:0] Vj;
    logic [DATA_W-1:0] Vk;
    logic [TAG_W-1:0]  Qj;
    logic [TAG_W-1:0]  Qk;
    logic [OP_W-1:0]   Ufop;
    logic [REG_W-1:0]  R_target;
    logic              Cdb_valid;
    logic [TAG_W-1:0]  Cdb_tag;
    logic [DATA_W-1:0] Cdb_data;
    logic              Cdb_grant;
    logic              Busy;
    logic              Cdb_req;
    logic [TAG_W-1:0]  Cdb_tag_out;
    logic [DATA_W-1:0] Cdb_data_out;
    logic [REG_W-1:0]  Cdb_target;

    // Dispatcher / bus side
    modport master (
        output Enable_VQ, Vj, Vk, Qj, Qk, Ufop, R_target,
        output Cdb_valid, Cdb_tag, Cdb_data, Cdb_grant,
        input  Busy, Cdb_req, Cdb_tag_out, Cdb_data_out, Cdb_target
    );

    // Reservation station side
    modport slave (
        input  Enable_VQ, Vj, Vk, Qj, Qk, Ufop, R_target,
        input  Cdb_valid, Cdb_tag, Cdb_data, Cdb_grant,
        output Busy, Cdb_req, Cdb_tag_out, Cdb_data_out, Cdb_target
    );

endinterface

// File: rtl/reservation_station_add_alu.sv
// Combinational ALU of the add station: ADD/SUB wrap modulo 2^16, AND/OR bitwise.
module rs_alu
    import tomasulo_pkg::*;
(
    input  logic [OP_W-1:0]   Ufop,
    input  logic [DATA_W-1:0] Vj,
    input  logic [DATA_W-1:0] Vk,
    output logic [DATA_W-1:0] result
);

    // Opcode decode; unknown opcodes produce zero
    always_comb begin
        result = '0;
        case (Ufop)
            OP_ADD:  result = DATA_W'(Vj + Vk);
            OP_SUB:  result = DATA_W'(Vj - Vk);
            OP_AND:  result = Vj & Vk;
            OP_OR:   result = Vj | Vk;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reservation_station_add.sv
// Single-entry add/sub/and/or reservation station for a Tomasulo core.
// Optional feature: define RS_OVERRUN_DETECT_EN to add a sticky Overrun output
// flagging dispatch attempts while the station is occupied.
module reservation_station_add
    import tomasulo_pkg::*;
#(
    parameter logic [TAG_W-1:0] MY_TAG      = 3'd1,
    parameter int unsigned      ADD_LATENCY = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
`ifdef RS_OVERRUN_DETECT_EN
    output logic                      Overrun,
`endif
    reservation_station_add_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY - 1);

    localparam rs_entry_t ENTRY_RST = '{
        vj:       VJ_VK_SEM_VALOR,
        vk:       VJ_VK_SEM_VALOR,
        qj:       QJ_QK_SEM_VALOR,
        qk:       QJ_QK_SEM_VALOR,
        ufop:     3'b000,
        r_target: 4'h0
    };

    localparam cdb_payload_t BCAST_IDLE = '{
        tag:    QJ_QK_SEM_VALOR,
        data:   VJ_VK_SEM_VALOR,
        target: 4'h0
    };

    rs_state_e         state_q, state_d;
    rs_entry_t         entry_q, entry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cdb_req_q, cdb_req_d;
    cdb_payload_t      bcast_q, bcast_d;
    logic [DATA_W-1:0] alu_result;
    logic              snoop_ok;
`ifdef RS_OVERRUN_DETECT_EN
    logic              overrun_q, overrun_d;
`endif

    rs_alu u_alu (
        .Ufop   (entry_q.ufop),
        .Vj     (entry_q.vj),
        .Vk     (entry_q.vk),
        .result (alu_result)
    );

    // A broadcast is usable only if it carries a real tag that is not our own
    assign snoop_ok = bus.Cdb_valid && (bus.Cdb_tag != QJ_QK_SEM_VALOR)
                      && (bus.Cdb_tag != MY_TAG);

    // Next-state, operand capture, latency counter and broadcast payload
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        cdb_req_d = 1'b0;
        bcast_d   = BCAST_IDLE;
`ifdef RS_OVERRUN_DETECT_EN
        overrun_d = overrun_q | (bus.Enable_VQ && (state_q != IDLE));
`endif
        case (state_q)
            IDLE: begin
                if (bus.Enable_VQ) begin
                    entry_d.vj       = bus.Vj;
                    entry_d.vk       = bus.Vk;
                    entry_d.qj       = bus.Qj;
                    entry_d.qk       = bus.Qk;
                    entry_d.ufop     = bus.Ufop;
                    entry_d.r_target = bus.R_target;
                    if (snoop_ok && (bus.Qj == bus.Cdb_tag)) begin
                        entry_d.vj = bus.Cdb_data;
                        entry_d.qj = QJ_QK_SEM_VALOR;
                    end
                    if (snoop_ok && (bus.Qk == bus.Cdb_tag)) begin
                        entry_d.vk = bus.Cdb_data;
                        entry_d.qk = QJ_QK_SEM_VALOR;
                    end
                    if ((entry_d.qj == QJ_QK_SEM_VALOR) && (entry_d.qk == QJ_QK_SEM_VALOR)) begin
                        state_d = EXEC;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = WAIT_OPS;
                    end
                end
            end
            WAIT_OPS: begin
                if (snoop_ok && (entry_q.qj == bus.Cdb_tag)) begin
                    entry_d.vj = bus.Cdb_data;
                    entry_d.qj = QJ_QK_SEM_VALOR;
                end
                if (snoop_ok && (entry_q.qk == bus.Cdb_tag)) begin
                    entry_d.vk = bus.Cdb_data;
                    entry_d.qk = QJ_QK_SEM_VALOR;
                end
                if ((entry_d.qj == QJ_QK_SEM_VALOR) && (entry_d.qk == QJ_QK_SEM_VALOR)) begin
                    state_d = EXEC;
                    cnt_d   = CNT_LOAD;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d   = WRITEBACK;
                    cdb_req_d = 1'b1;
                    bcast_d   = '{tag: MY_TAG, data: alu_result, target: entry_q.r_target};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITEBACK: begin
                if (bus.Cdb_grant) begin
                    state_d = IDLE;
                end else begin
                    cdb_req_d = 1'b1;
                    bcast_d   = bcast_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending instruction
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            entry_q   <= ENTRY_RST;
            cnt_q     <= '0;
            cdb_req_q <= 1'b0;
            bcast_q   <= BCAST_IDLE;
`ifdef RS_OVERRUN_DETECT_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            cdb_req_q <= cdb_req_d;
            bcast_q   <= bcast_d;
`ifdef RS_OVERRUN_DETECT_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    // Busy covers the load cycle so the dispatcher cannot double-issue
    assign bus.Busy         = (state_q != IDLE) || bus.Enable_VQ;
    assign bus.Cdb_req      = cdb_req_q;
    assign bus.Cdb_tag_out  = bcast_q.tag;
    assign bus.Cdb_data_out = bcast_q.data;
    assign bus.Cdb_target   = bcast_q.target;
`ifdef RS_OVERRUN_DETECT_EN
    assign Overrun          = overrun_q;
`endif

endmodule
